// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the issue/execute pipeline and the reorder buffer.
// The pipeline side uses the master modport; the ROB uses the slave modport.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 clearIn;
  logic                 issueValid;
  logic [4:0]           issueDest;
  logic                 issueIsBranch;
  logic                 issueReady;
  logic [31:0]          issueValue;
  logic [ROB_WIDTH-1:0] issueRobId;
  logic                 robFull;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobId;
  logic [31:0]          cdbValue;
  logic                 cdbMispredict;
  logic [31:0]          cdbTarget;
  logic [ROB_WIDTH-1:0] robRs1Dep;
  logic [ROB_WIDTH-1:0] robRs2Dep;
  logic                 robRs1Ready;
  logic                 robRs2Ready;
  logic [31:0]          robRs1Value;
  logic [31:0]          robRs2Value;
  logic                 regUpdateValid;
  logic [4:0]           regUpdateDest;
  logic [31:0]          regUpdateValue;
  logic [ROB_WIDTH-1:0] regUpdateRobId;
  logic                 clearOut;
  logic [31:0]          newPc;

  modport master (
    output clearIn, issueValid, issueDest, issueIsBranch, issueReady, issueValue,
           cdbValid, cdbRobId, cdbValue, cdbMispredict, cdbTarget,
           robRs1Dep, robRs2Dep,
    input  issueRobId, robFull, robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
           regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
           clearOut, newPc
  );

  modport slave (
    input  clearIn, issueValid, issueDest, issueIsBranch, issueReady, issueValue,
           cdbValid, cdbRobId, cdbValue, cdbMispredict, cdbTarget,
           robRs1Dep, robRs2Dep,
    output issueRobId, robFull, robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
           regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
           clearOut, newPc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion via CDB,
// in-order single-entry commit with branch-mispredict flush.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input logic             clockIn,
  input logic             resetIn,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] DEPTH_CNT = {1'b1, {ROB_WIDTH{1'b0}}};
  typedef logic [ROB_WIDTH-1:0] idx_t;

  idx_t               head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0] count_q, count_d;
  logic [DEPTH-1:0]   busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]   branch_q, branch_d, mispred_q, mispred_d;
  logic [4:0]         dest_q   [DEPTH];
  logic [4:0]         dest_d   [DEPTH];
  logic [31:0]        value_q  [DEPTH];
  logic [31:0]        value_d  [DEPTH];
  logic [31:0]        target_q [DEPTH];
  logic [31:0]        target_d [DEPTH];

  logic               reg_valid_q, reg_valid_d;
  logic [4:0]         reg_dest_q, reg_dest_d;
  logic [31:0]        reg_value_q, reg_value_d;
  idx_t               reg_id_q, reg_id_d;
  logic               clear_out_q, clear_out_d;
  logic [31:0]        new_pc_q, new_pc_d;

  logic full, do_issue, do_commit, commit_write, commit_flush;
  logic rs1_bypass, rs2_bypass;

  // Full and commit eligibility come from pre-edge state only, so a commit
  // in the same cycle never frees a slot for a blocked issue.
  assign full         = (count_q == DEPTH_CNT);
  assign do_issue     = rob.issueValid && !full;
  assign do_commit    = (count_q != '0) && ready_q[head_q];
  assign commit_write = do_commit && !branch_q[head_q];
  assign commit_flush = do_commit && branch_q[head_q] && mispred_q[head_q];

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    branch_d    = branch_q;
    mispred_d   = mispred_q;
    dest_d      = dest_q;
    value_d     = value_q;
    target_d    = target_q;
    reg_valid_d = 1'b0;
    reg_dest_d  = reg_dest_q;
    reg_value_d = reg_value_q;
    reg_id_d    = reg_id_q;
    clear_out_d = 1'b0;
    new_pc_d    = new_pc_q;

    if (rob.cdbValid && busy_q[rob.cdbRobId]) begin
      ready_d[rob.cdbRobId]   = 1'b1;
      value_d[rob.cdbRobId]   = rob.cdbValue;
      mispred_d[rob.cdbRobId] = rob.cdbMispredict;
      target_d[rob.cdbRobId]  = rob.cdbTarget;
    end

    if (do_issue) begin
      busy_d[tail_q]    = 1'b1;
      ready_d[tail_q]   = rob.issueReady;
      branch_d[tail_q]  = rob.issueIsBranch;
      mispred_d[tail_q] = 1'b0;
      dest_d[tail_q]    = rob.issueDest;
      value_d[tail_q]   = rob.issueValue;
      tail_d            = tail_q + idx_t'(1);
    end

    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + idx_t'(1);
    end

    count_d = count_q + (ROB_WIDTH+1)'(do_issue) - (ROB_WIDTH+1)'(do_commit);

    if (commit_write) begin
      reg_valid_d = 1'b1;
      reg_dest_d  = dest_q[head_q];
      reg_value_d = value_q[head_q];
      reg_id_d    = head_q;
    end

    if (commit_flush) begin
      clear_out_d = 1'b1;
      new_pc_d    = target_q[head_q];
    end

    // A flush (external or mispredict) discards everything, including a
    // same-cycle issue or CDB write.
    if (commit_flush || rob.clearIn) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end

    if (rob.clearIn) begin
      reg_valid_d = 1'b0;
      clear_out_d = 1'b0;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      reg_valid_q <= 1'b0;
      reg_dest_q  <= '0;
      reg_value_q <= '0;
      reg_id_q    <= '0;
      clear_out_q <= 1'b0;
      new_pc_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      reg_valid_q <= reg_valid_d;
      reg_dest_q  <= reg_dest_d;
      reg_value_q <= reg_value_d;
      reg_id_q    <= reg_id_d;
      clear_out_q <= clear_out_d;
      new_pc_q    <= new_pc_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clockIn) begin
    branch_q  <= branch_d;
    mispred_q <= mispred_d;
    dest_q    <= dest_d;
    value_q   <= value_d;
    target_q  <= target_d;
  end

  assign rs1_bypass = rob.cdbValid && (rob.cdbRobId == rob.robRs1Dep);
  assign rs2_bypass = rob.cdbValid && (rob.cdbRobId == rob.robRs2Dep);

  assign rob.robRs1Ready    = ready_q[rob.robRs1Dep] || rs1_bypass;
  assign rob.robRs2Ready    = ready_q[rob.robRs2Dep] || rs2_bypass;
  assign rob.robRs1Value    = rs1_bypass ? rob.cdbValue : value_q[rob.robRs1Dep];
  assign rob.robRs2Value    = rs2_bypass ? rob.cdbValue : value_q[rob.robRs2Dep];

  assign rob.issueRobId     = tail_q;
  assign rob.robFull        = full;
  assign rob.regUpdateValid = reg_valid_q;
  assign rob.regUpdateDest  = reg_dest_q;
  assign rob.regUpdateValue = reg_value_q;
  assign rob.regUpdateRobId = reg_id_q;
  assign rob.clearOut       = clear_out_q;
  assign rob.newPc          = new_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all
// checked against a queue-based model of in-order allocate/commit.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_WIDTH(4)) bi ();
  reorder_buffer #(.ROB_WIDTH(4)) dut (.clockIn(clk), .resetIn(rst), .rob(bi));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [4:0]  dest;
    bit          br;
    bit          rdy;
    bit          mis;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail = 0;
  bit          synced = 0;
  bit          exp_rv = 0, exp_co = 0, exp_zero = 0;
  logic [4:0]  exp_dest;
  logic [31:0] exp_val, exp_pc;
  int          exp_id;

  task automatic find(input int id, output int k);
    k = -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].id == id) k = i;
  endtask

  task automatic idle();
    rst              = 1'b0;
    bi.clearIn       = 1'b0;
    bi.issueValid    = 1'b0;
    bi.issueDest     = '0;
    bi.issueIsBranch = 1'b0;
    bi.issueReady    = 1'b0;
    bi.issueValue    = '0;
    bi.cdbValid      = 1'b0;
    bi.cdbRobId      = '0;
    bi.cdbValue      = '0;
    bi.cdbMispredict = 1'b0;
    bi.cdbTarget     = '0;
    bi.robRs1Dep     = '0;
    bi.robRs2Dep     = '0;
  endtask

  task automatic set_issue(input logic [4:0] d, input bit br, input bit rdy, input logic [31:0] v);
    bi.issueValid    = 1'b1;
    bi.issueDest     = d;
    bi.issueIsBranch = br;
    bi.issueReady    = rdy;
    bi.issueValue    = v;
  endtask

  task automatic check_query(input string tag, input logic [3:0] dep, input logic rdy, input logic [31:0] v);
    int k;
    if (bi.cdbValid && bi.cdbRobId == dep) begin
      chk({tag, "_byp_rdy"}, rdy, 1);
      chk({tag, "_byp_val"}, v, bi.cdbValue);
    end else begin
      find(dep, k);
      if (k >= 0) begin
        chk({tag, "_rdy"}, rdy, mq[k].rdy);
        if (mq[k].rdy) chk({tag, "_val"}, v, mq[k].val);
      end
    end
  endtask

  task automatic check_comb();
    chk("issue_id", bi.issueRobId, m_tail);
    chk("full", bi.robFull, mq.size() == 16);
    check_query("rs1", bi.robRs1Dep, bi.robRs1Ready, bi.robRs1Value);
    check_query("rs2", bi.robRs2Dep, bi.robRs2Ready, bi.robRs2Value);
  endtask

  task automatic model_update();
    ent_t c;
    bit   commit;
    int   k;
    if (rst) begin
      mq.delete();
      m_tail = 0; exp_rv = 0; exp_co = 0; exp_zero = 1; synced = 1;
      return;
    end
    exp_zero = 0;
    if (bi.clearIn) begin
      mq.delete();
      m_tail = 0; exp_rv = 0; exp_co = 0;
      return;
    end
    commit = (mq.size() > 0) && mq[0].rdy;
    if (commit) c = mq[0];
    if (bi.cdbValid) begin
      find(int'(bi.cdbRobId), k);
      if (k >= 0) begin
        mq[k].rdy = 1;
        mq[k].val = bi.cdbValue;
        mq[k].mis = bi.cdbMispredict;
        mq[k].tgt = bi.cdbTarget;
      end
    end
    if (bi.issueValid && mq.size() < 16) begin
      mq.push_back('{id: m_tail, dest: bi.issueDest, br: bi.issueIsBranch,
                     rdy: bi.issueReady, mis: 1'b0, val: bi.issueValue, tgt: 32'h0});
      m_tail = (m_tail + 1) % 16;
    end
    exp_rv = 0;
    exp_co = 0;
    if (commit) begin
      mq.delete(0);
      if (!c.br) begin
        exp_rv = 1; exp_dest = c.dest; exp_val = c.val; exp_id = c.id;
      end else if (c.mis) begin
        exp_co = 1; exp_pc = c.tgt;
        mq.delete();
        m_tail = 0;
      end
    end
  endtask

  task automatic check_regs();
    chk("reg_valid", bi.regUpdateValid, exp_rv);
    if (exp_rv) begin
      chk("reg_dest", bi.regUpdateDest, exp_dest);
      chk("reg_value", bi.regUpdateValue, exp_val);
      chk("reg_id", bi.regUpdateRobId, exp_id);
    end
    chk("clear_out", bi.clearOut, exp_co);
    if (exp_co) chk("new_pc", bi.newPc, exp_pc);
    if (exp_zero) begin
      chk("rst_dest", bi.regUpdateDest, 0);
      chk("rst_value", bi.regUpdateValue, 0);
      chk("rst_id", bi.regUpdateRobId, 0);
      chk("rst_pc", bi.newPc, 0);
    end
  endtask

  // Inputs are set at the falling edge; one call spans one rising edge.
  task automatic cyc();
    #1;
    if (synced) check_comb();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    idle();
    @(negedge clk);
    do_reset();
    chk("reset_full", bi.robFull, 0);
    chk("reset_tail", bi.issueRobId, 0);

    // Single issue completed over the CDB, committed two edges later.
    idle(); set_issue(5'd5, 0, 0, 32'h0); cyc();
    idle(); bi.cdbValid = 1; bi.cdbRobId = 0; bi.cdbValue = 32'h1234; cyc();
    idle(); cyc();
    chk("r17_valid", bi.regUpdateValid, 1);
    chk("r17_dest", bi.regUpdateDest, 5);
    chk("r17_value", bi.regUpdateValue, 32'h1234);
    chk("r17_id", bi.regUpdateRobId, 0);

    // Fill to capacity; the extra issue is dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle(); set_issue(5'(i), 0, 0, 32'(i)); cyc();
    end
    chk("r18_full", bi.robFull, 1);
    idle(); set_issue(5'd9, 0, 0, 32'h99); cyc();
    chk("r18_tail", bi.issueRobId, 0);
    chk("r18_full2", bi.robFull, 1);

    // Mispredicted branch behind three ready entries.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(5'(i + 1), 0, 1, 32'(i + 100)); cyc();
    end
    idle(); set_issue(5'd0, 1, 0, 32'h0); cyc();
    idle(); cyc();
    idle(); cyc();
    idle(); bi.cdbValid = 1; bi.cdbRobId = 3; bi.cdbMispredict = 1; bi.cdbTarget = 32'h100; cyc();
    idle(); cyc();
    chk("r19_clear", bi.clearOut, 1);
    chk("r19_pc", bi.newPc, 32'h100);
    idle(); cyc();
    chk("r19_clear_end", bi.clearOut, 0);
    chk("r19_full", bi.robFull, 0);
    chk("r19_tail", bi.issueRobId, 0);

    // Same-cycle CDB bypass on an operand query.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(5'(i), 0, 0, 32'h0); cyc();
    end
    idle(); bi.cdbValid = 1; bi.cdbRobId = 2; bi.cdbValue = 32'hBEEF; bi.robRs1Dep = 2;
    #1;
    chk("r20_rdy", bi.robRs1Ready, 1);
    chk("r20_val", bi.robRs1Value, 32'hBEEF);
    cyc();

    // Twenty back-to-back ready issues wrap the index space.
    do_reset();
    n = 0;
    for (int i = 0; i < 23; i++) begin
      idle();
      if (i < 20) set_issue(5'(i), 0, 1, 32'(i * 3));
      cyc();
      if (bi.regUpdateValid) begin
        chk("r21_id", bi.regUpdateRobId, n % 16);
        n++;
      end
    end
    chk("r21_count", n, 20);

    // Reset while the head entry is ready to commit.
    do_reset();
    idle(); set_issue(5'd7, 0, 1, 32'h77); cyc();
    idle(); rst = 1; cyc(); rst = 0;
    chk("r22_valid", bi.regUpdateValid, 0);
    chk("r22_value", bi.regUpdateValue, 0);
    chk("r22_clear", bi.clearOut, 0);
    chk("r22_pc", bi.newPc, 0);

    // Randomized traffic with alternating light and heavy issue phases.
    for (int i = 0; i < 1500; i++) begin
      idle();
      rst              = ($urandom_range(299) == 0);
      bi.clearIn       = ($urandom_range(99) == 0);
      bi.issueValid    = ($urandom_range(9) < ((((i / 200) % 2) != 0) ? 8 : 3));
      bi.issueDest     = 5'($urandom);
      bi.issueIsBranch = ($urandom_range(5) == 0);
      bi.issueReady    = ($urandom_range(3) == 0);
      bi.issueValue    = $urandom;
      if ($urandom_range(1) == 0) begin
        bi.cdbValid = 1;
        if (mq.size() > 0 && $urandom_range(3) != 0) begin
          k = int'($urandom_range(mq.size() - 1));
          bi.cdbRobId      = 4'(mq[k].id);
          bi.cdbMispredict = mq[k].br && ($urandom_range(3) == 0);
        end else begin
          bi.cdbRobId = 4'($urandom);
        end
        bi.cdbValue  = $urandom;
        bi.cdbTarget = $urandom;
      end
      bi.robRs1Dep = ($urandom_range(3) == 0) ? bi.cdbRobId : 4'($urandom);
      bi.robRs2Dep = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
